// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_ctrl
// Description : Button synchroniser/debouncer and IDLE/RUN/PAUSE sequencer
//               driving the stopwatch counter, clear, lap capture and lap hold.
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl #(
  parameter int DB_CYCLES = 24000,
  parameter int DB_W      = 15,
  parameter int LAP_TICKS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_in,
  input  logic       tick,
  output logic       count_en,
  output logic       clear,
  output logic       lap_capture,
  output logic       show_lap,
  output logic [1:0] state
);

  localparam logic [DB_W-1:0] c_db_last = DB_W'(DB_CYCLES - 1);
  localparam logic [DB_W-1:0] c_db_one  = DB_W'(1);
  localparam logic [4:0]      c_lap_ld  = 5'(LAP_TICKS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10
  } state_t;

  state_t     r_state;
  logic       r_clear;
  logic       r_lap_cap;
  logic       r_show;
  logic [4:0] r_lap_cnt;
  logic [4:0] w_lap_nxt;
  logic [3:0] w_press;
  logic       w_clr_p, w_stop_p, w_start_p, w_lap_p, w_lap_load;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    logic            r_s1, r_s2, r_deb, r_deb_d, r_press;
    logic [DB_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_s1    <= 1'b0;
        r_s2    <= 1'b0;
        r_deb   <= 1'b0;
        r_deb_d <= 1'b0;
        r_press <= 1'b0;
        r_cnt   <= '0;
      end else begin
        r_s1 <= btn_in[i];
        r_s2 <= r_s1;
        if (r_s2 == r_deb) begin
          r_cnt <= '0;
        end else if (r_cnt == c_db_last) begin
          r_deb <= r_s2;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + c_db_one;
        end
        r_deb_d <= r_deb;
        r_press <= r_deb & ~r_deb_d;
      end
    end

    assign w_press[i] = r_press;
  end

  // Single winner per cycle: clear > stop > start > lap
  assign w_clr_p    = w_press[0];
  assign w_stop_p   = w_press[1] & ~w_press[0];
  assign w_start_p  = w_press[3] & ~w_press[1] & ~w_press[0];
  assign w_lap_p    = w_press[2] & ~w_press[3] & ~w_press[1] & ~w_press[0];
  assign w_lap_load = w_lap_p & (r_state == S_RUN);

  always_comb begin
    w_lap_nxt = r_lap_cnt;
    if (w_lap_load) begin
      w_lap_nxt = c_lap_ld;
    end else if (w_clr_p) begin
      w_lap_nxt = 5'd0;
    end else if (tick && (r_lap_cnt != 5'd0)) begin
      w_lap_nxt = r_lap_cnt - 5'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_clear   <= 1'b0;
      r_lap_cap <= 1'b0;
      r_lap_cnt <= 5'd0;
      r_show    <= 1'b0;
    end else begin
      r_clear   <= w_clr_p;
      r_lap_cap <= w_lap_load;
      r_lap_cnt <= w_lap_nxt;
      r_show    <= (w_lap_nxt != 5'd0);
      case (r_state)
        S_IDLE: begin
          if (w_start_p) r_state <= S_RUN;
        end
        S_RUN: begin
          if (w_clr_p)       r_state <= S_IDLE;
          else if (w_stop_p) r_state <= S_PAUSE;
        end
        S_PAUSE: begin
          if (w_clr_p)        r_state <= S_IDLE;
          else if (w_start_p) r_state <= S_RUN;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Uses the registered state, so a tick alongside a stop press still counts
  assign count_en    = tick & (r_state == S_RUN);
  assign clear       = r_clear;
  assign lap_capture = r_lap_cap;
  assign show_lap    = r_show;
  assign state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_stopwatch_ctrl
// Description : Directed vector table plus corner-case sequences for
//               stopwatch_ctrl (DB_CYCLES=4, LAP_TICKS=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] btn_in = 4'b0000;
  logic       tick_gen = 1'b0;
  logic       tick_force = 1'b0;
  logic       tick_auto = 1'b0;
  logic       tick;
  logic       count_en, clear, lap_capture, show_lap;
  logic [1:0] state;

  int n_checks = 0;
  int n_fail   = 0;
  int n_clr = 0, n_cap = 0, n_en = 0, n_tick = 0;
  bit pause_seen = 1'b0;
  int tcnt = 0;

  typedef struct {
    logic [3:0] btn;
    int         hold;
    logic [1:0] st;
    int         clr;
    int         cap;
    logic       show;
  } vec_t;

  vec_t tbl[17];

  assign tick = tick_gen | tick_force;

  stopwatch_ctrl #(
    .DB_CYCLES(4),
    .DB_W     (4),
    .LAP_TICKS(3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_in     (btn_in),
    .tick       (tick),
    .count_en   (count_en),
    .clear      (clear),
    .lap_capture(lap_capture),
    .show_lap   (show_lap),
    .state      (state)
  );

  always #5 clk = ~clk;

  // Free-running time base: first tick one cycle after enable, then every 10
  always @(posedge clk) begin
    #1;
    if (!tick_auto) begin
      tcnt     = 0;
      tick_gen = 1'b0;
    end else begin
      tick_gen = (tcnt == 0);
      tcnt     = (tcnt == 9) ? 0 : tcnt + 1;
    end
  end

  always @(negedge clk) begin
    if (clear)          n_clr++;
    if (lap_capture)    n_cap++;
    if (count_en)       n_en++;
    if (tick)           n_tick++;
    if (state == 2'b10) pause_seen = 1'b1;
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic clr_counts();
    n_clr = 0;
    n_cap = 0;
    n_en = 0;
    n_tick = 0;
    pause_seen = 1'b0;
  endtask

  task automatic press(input logic [3:0] b, input int hold);
    btn_in = b;
    repeat (hold) cyc();
    btn_in = 4'b0000;
    repeat (12) cyc();
  endtask

  task automatic mtick();
    tick_force = 1'b1;
    cyc();
    tick_force = 1'b0;
    cyc();
  endtask

  initial begin
    tbl[0]  = '{4'b1000, 3, 2'b00, 0, 0, 1'b0};
    tbl[1]  = '{4'b0100, 6, 2'b00, 0, 0, 1'b0};
    tbl[2]  = '{4'b0010, 6, 2'b00, 0, 0, 1'b0};
    tbl[3]  = '{4'b0001, 6, 2'b00, 1, 0, 1'b0};
    tbl[4]  = '{4'b1000, 6, 2'b01, 0, 0, 1'b0};
    tbl[5]  = '{4'b1000, 6, 2'b01, 0, 0, 1'b0};
    tbl[6]  = '{4'b0010, 6, 2'b10, 0, 0, 1'b0};
    tbl[7]  = '{4'b0100, 6, 2'b10, 0, 0, 1'b0};
    tbl[8]  = '{4'b0010, 6, 2'b10, 0, 0, 1'b0};
    tbl[9]  = '{4'b1000, 6, 2'b01, 0, 0, 1'b0};
    tbl[10] = '{4'b0100, 6, 2'b01, 0, 1, 1'b1};
    tbl[11] = '{4'b0010, 6, 2'b10, 0, 0, 1'b1};
    tbl[12] = '{4'b0001, 6, 2'b00, 1, 0, 1'b0};
    tbl[13] = '{4'b1010, 6, 2'b00, 0, 0, 1'b0};
    tbl[14] = '{4'b1000, 6, 2'b01, 0, 0, 1'b0};
    tbl[15] = '{4'b1100, 6, 2'b01, 0, 0, 1'b0};
    tbl[16] = '{4'b0001, 6, 2'b00, 1, 0, 1'b0};

    // Asynchronous reset before any clock edge
    #2 rst = 1'b1;
    #1;
    chk("rst_state", state, 0);
    chk("rst_clear", clear, 0);
    chk("rst_lapcap", lap_capture, 0);
    chk("rst_show", show_lap, 0);
    chk("rst_count_en", count_en, 0);
    repeat (3) cyc();
    rst = 1'b0;
    cyc();

    for (int i = 0; i < 17; i++) begin
      clr_counts();
      press(tbl[i].btn, tbl[i].hold);
      chk($sformatf("vec%0d_state", i), state, tbl[i].st);
      chk($sformatf("vec%0d_clears", i), n_clr, tbl[i].clr);
      chk($sformatf("vec%0d_caps", i), n_cap, tbl[i].cap);
      chk($sformatf("vec%0d_show", i), show_lap, tbl[i].show);
    end

    // Start latency: state changes on the 8th edge counting the first sample
    btn_in = 4'b1000;
    repeat (7) cyc();
    chk("lat_before", state, 0);
    cyc();
    chk("lat_at", state, 1);
    repeat (2) cyc();
    btn_in = 4'b0000;
    clr_counts();
    repeat (15) cyc();
    chk("release_state", state, 1);
    chk("release_clears", n_clr, 0);
    chk("release_caps", n_cap, 0);

    // Counting in RUN, frozen in PAUSE, resumed in RUN
    clr_counts();
    tick_auto = 1'b1;
    repeat (50) cyc();
    tick_auto = 1'b0;
    chk("run_ticks", n_tick, 5);
    chk("run_count_en", n_en, 5);
    press(4'b0010, 6);
    chk("stop_state", state, 2);
    clr_counts();
    tick_auto = 1'b1;
    repeat (30) cyc();
    tick_auto = 1'b0;
    chk("pause_ticks", n_tick, 3);
    chk("pause_count_en", n_en, 0);
    press(4'b1000, 6);
    chk("resume_state", state, 1);
    clr_counts();
    tick_auto = 1'b1;
    repeat (30) cyc();
    tick_auto = 1'b0;
    chk("resume_count_en", n_en, 3);

    // Lap hold drops after the third tick
    clr_counts();
    press(4'b0100, 6);
    chk("lap_caps", n_cap, 1);
    chk("lap_show", show_lap, 1);
    tick_auto = 1'b1;
    repeat (21) cyc();
    chk("lap_show_2ticks", show_lap, 1);
    cyc();
    chk("lap_show_3ticks", show_lap, 0);
    tick_auto = 1'b0;
    repeat (3) cyc();

    // Reload during an active hold
    press(4'b0100, 6);
    clr_counts();
    tick_auto = 1'b1;
    repeat (13) cyc();
    btn_in = 4'b0100;
    repeat (6) cyc();
    btn_in = 4'b0000;
    repeat (3) cyc();
    chk("reload_show", show_lap, 1);
    chk("reload_caps", n_cap, 1);
    repeat (19) cyc();
    chk("reload_show_late", show_lap, 1);
    cyc();
    chk("reload_show_end", show_lap, 0);
    tick_auto = 1'b0;
    repeat (3) cyc();

    // Lap load coincident with a tick: load wins, three more ticks needed
    btn_in = 4'b0100;
    repeat (7) cyc();
    tick_force = 1'b1;
    cyc();
    tick_force = 1'b0;
    btn_in = 4'b0000;
    chk("lapcoin_show", show_lap, 1);
    repeat (12) cyc();
    mtick();
    mtick();
    chk("lapcoin_show_2", show_lap, 1);
    mtick();
    chk("lapcoin_show_3", show_lap, 0);

    // Stop press coincident with a tick: that tick still counts
    btn_in = 4'b0010;
    repeat (7) cyc();
    tick_force = 1'b1;
    #1;
    chk("stopcoin_count_en", count_en, 1);
    chk("stopcoin_state_run", state, 1);
    cyc();
    tick_force = 1'b0;
    btn_in = 4'b0000;
    #1;
    chk("stopcoin_state", state, 2);
    chk("stopcoin_count_en_off", count_en, 0);
    repeat (12) cyc();

    // Priority: clear beats stop and start together in RUN
    press(4'b1000, 6);
    press(4'b0100, 6);
    chk("prio_show_pre", show_lap, 1);
    clr_counts();
    press(4'b1011, 6);
    chk("prio_state", state, 0);
    chk("prio_clears", n_clr, 1);
    chk("prio_show", show_lap, 0);
    chk("prio_no_pause", pause_seen, 0);

    // Asynchronous reset mid-RUN with a hold active and a tick present
    press(4'b1000, 6);
    press(4'b0100, 6);
    tick_force = 1'b1;
    #1;
    chk("arst_count_en_pre", count_en, 1);
    chk("arst_show_pre", show_lap, 1);
    #1 rst = 1'b1;
    #1;
    chk("arst_state", state, 0);
    chk("arst_show", show_lap, 0);
    chk("arst_count_en", count_en, 0);
    chk("arst_clear", clear, 0);
    chk("arst_lapcap", lap_capture, 0);
    tick_force = 1'b0;
    repeat (2) cyc();
    rst = 1'b0;
    repeat (3) cyc();
    chk("arst_after", state, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
